// File: rtl/i_sync_db_pkg.sv
// -----------------------------------------------------------------------------
// i_sync_db_pkg
// Shared constants and helpers for the multi-channel input conditioner.
//   SS_MIN / SS_MAX : legal synchronizer depth range
//   DBC_MAX         : largest supported debounce length
//   calc_cw()       : debounce counter width for a given debounce length
// -----------------------------------------------------------------------------
package i_sync_db_pkg;

    localparam int SS_MIN  = 32'sd2;
    localparam int SS_MAX  = 32'sd4;
    localparam int DBC_MAX = 32'sd255;

    // Counter width able to hold 0..dbc, never narrower than one bit.
    function automatic int calc_cw(input int dbc);
        int w;
        w = $clog2(dbc + 32'sd1);
        if (w < 32'sd1) begin
            calc_cw = 32'sd1;
        end else begin
            calc_cw = w;
        end
    endfunction

endpackage

// File: rtl/i_sync_db_ch.sv
// -----------------------------------------------------------------------------
// i_sync_db_ch
// One conditioner channel: SS-stage synchronizer, optional debounce counter
// and registered output/change flops.
// Parameters: SS (sync depth), RS (reset level), DBC (debounce length, 0 = bypass)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : debounce tick
//   i    : asynchronous raw input
//   o    : conditioned level
//   chg  : one-cycle pulse coincident with a toggle of o
//   rise : one-cycle pulse on a 0->1 toggle (only with I_SYNC_DB_EDGE_EN)
//   fall : one-cycle pulse on a 1->0 toggle (only with I_SYNC_DB_EDGE_EN)
// -----------------------------------------------------------------------------
module i_sync_db_ch
    import i_sync_db_pkg::*;
#(
    parameter int   SS  = 32'sd2,
    parameter logic RS  = 1'b0,
    parameter int   DBC = 32'sd0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic i,
    output logic o,
    output logic chg
`ifdef I_SYNC_DB_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    logic [SS-1:0] sync_r;
    logic          s_s;
    logic          upd_s;
    logic          o_r;
    logic          chg_r;
`ifdef I_SYNC_DB_EDGE_EN
    logic          rise_r;
    logic          fall_r;
`endif

    // Synchronizer chain: stage 0 samples the raw input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SS{RS}};
        end else begin
            sync_r <= {sync_r[SS-2:0], i};
        end
    end

    assign s_s = sync_r[SS-1];

    generate
        if (DBC > 32'sd0) begin : g_filt
            localparam int CW = calc_cw(DBC);
            localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
            localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DBC - 32'sd1);

            logic [CW-1:0] cnt_r;
            logic [CW-1:0] cnt_nxt_s;
            logic          upd_f_s;

            // Debounce counter next state; compares against the pre-edge s.
            always_comb begin
                cnt_nxt_s = cnt_r;
                upd_f_s   = 1'b0;
                if (s_s == o_r) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (en) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_nxt_s = CNT_ZERO;
                        upd_f_s   = 1'b1;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r;
                end
            end

            // Debounce counter register; reset discards any partial count.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_r <= CNT_ZERO;
                end else begin
                    cnt_r <= cnt_nxt_s;
                end
            end

            assign upd_s = upd_f_s;
        end else begin : g_byp
            // Without a filter the tick is irrelevant.
            logic unused_en_s;
            assign unused_en_s = en;
            assign upd_s       = s_s ^ o_r;
        end
    endgenerate

    // Output level and change/edge pulses; a toggle always flips o towards s.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_r    <= RS;
            chg_r  <= 1'b0;
`ifdef I_SYNC_DB_EDGE_EN
            rise_r <= 1'b0;
            fall_r <= 1'b0;
`endif
        end else begin
            o_r    <= o_r ^ upd_s;
            chg_r  <= upd_s;
`ifdef I_SYNC_DB_EDGE_EN
            rise_r <= upd_s & s_s;
            fall_r <= upd_s & ~s_s;
`endif
        end
    end

    assign o    = o_r;
    assign chg  = chg_r;
`ifdef I_SYNC_DB_EDGE_EN
    assign rise = rise_r;
    assign fall = fall_r;
`endif

endmodule

// File: rtl/i_sync_db.sv
// -----------------------------------------------------------------------------
// i_sync_db
// Parametrised multi-channel input conditioner (synchronize, debounce, strobe).
// Optional feature macro: I_SYNC_DB_EDGE_EN adds the rise/fall outputs.
// Parameters: DW (channels), SS (sync stages 2..4), RS (reset level),
//             DBC (debounce length 0..255, 0 = bypass)
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   en   : debounce tick (tie high to count every clock)
//   i    : asynchronous raw inputs [DW]
//   o    : synchronized, debounced levels [DW]
//   chg  : one-cycle toggle pulses [DW]
//   rise : one-cycle 0->1 pulses [DW] (only with I_SYNC_DB_EDGE_EN)
//   fall : one-cycle 1->0 pulses [DW] (only with I_SYNC_DB_EDGE_EN)
// -----------------------------------------------------------------------------
module i_sync_db
    import i_sync_db_pkg::*;
#(
    parameter int   DW  = 32'sd1,
    parameter int   SS  = 32'sd2,
    parameter logic RS  = 1'b0,
    parameter int   DBC = 32'sd0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] o,
    output logic [DW-1:0] chg
`ifdef I_SYNC_DB_EDGE_EN
    ,
    output logic [DW-1:0] rise,
    output logic [DW-1:0] fall
`endif
);

    generate
        if ((SS < SS_MIN) || (SS > SS_MAX)) begin : g_bad_ss
            $error("i_sync_db: SS=%0d outside %0d..%0d", SS, SS_MIN, SS_MAX);
        end
        if ((DBC < 32'sd0) || (DBC > DBC_MAX)) begin : g_bad_dbc
            $error("i_sync_db: DBC=%0d outside 0..%0d", DBC, DBC_MAX);
        end

        for (genvar n = 0; n < DW; n++) begin : g_ch
            i_sync_db_ch #(
                .SS  (SS),
                .RS  (RS),
                .DBC (DBC)
            ) u_ch (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .i    (i[n]),
                .o    (o[n]),
                .chg  (chg[n])
`ifdef I_SYNC_DB_EDGE_EN
                ,
                .rise (rise[n]),
                .fall (fall[n])
`endif
            );
        end
    endgenerate

endmodule

// File: doc/i_sync_db.md
# i_sync_db

Parametrised multi-channel input conditioner. It is the successor to the plain two-flop input synchronizer and feeds clean levels and change strobes to the IO/CIA/joystick logic. Each channel has:
- a configurable-depth synchronizer chain;
- an optional per-channel debounce filter counting a shared enable strobe;
- a one-cycle change pulse whenever the filtered output toggles.

## Interface
Parameters:
- `DW`, 1: number of independent channels.
- `SS`, 2: synchronizer stages, legal range 2..4.
- `RS`, 1'b0: reset/power-up level of every stage, filtered output and counter-compare state.
- `DBC`, 0: debounce length in `en` strobes. 0 bypasses the filter. Legal range 0..255.
- `CW`, derived: counter width, `$clog2(DBC+1)`, minimum 1.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: debounce tick, for example a 1 kHz strobe. Tie to 1 to count every clock.
- `i` in DW: asynchronous raw inputs.
- `o` out DW: synchronized, debounced levels.
- `chg` out DW: one-cycle pulse on the cycle `o[n]` toggles.
- `rise` out DW: one-cycle pulse on a 0→1 change of `o[n]`. Present only with `I_SYNC_DB_EDGE_EN`.
- `fall` out DW: one-cycle pulse on a 1→0 change of `o[n]`. Present only with `I_SYNC_DB_EDGE_EN`.

## Operation
- **Sync chain:** per channel, `SS` flops, stage 0 samples `i`. `s[n]` denotes the last stage.
- **Filter, `DBC`>0:** a per-channel counter `cnt[n]`.
  - If `s[n]` == `o[n]`: `cnt[n]`<=0. Any bounce restarts the count.
  - If `s[n]` != `o[n]` and `en`=0: `cnt[n]` holds.
  - If `s[n]` != `o[n]`, `en`=1 and `cnt[n]` < `DBC`-1: `cnt[n]`++.
  - If `s[n]` != `o[n]`, `en`=1 and `cnt[n]` == `DBC`-1: `o[n]`<=`s[n]`, `cnt[n]`<=0, `chg[n]`<=1.
- **Bypass, `DBC`=0:** `o[n]`<=`s[n]` every cycle, and `chg[n]`<=`s[n]`^`o[n]`. No counter is generated.
- **`chg`:** registered, asserted exactly one cycle per toggle, coincident with the new `o` value.
- **Channel independence:** channels are fully independent. Simultaneous toggles on several channels produce simultaneous `chg` bits.
- **Reset:**
  - `rst`=1 forces all sync stages and `o` to `RS`, all `cnt` to 0, and `chg`/`rise`/`fall` to 0.
  - The same values are used as initial (power-up) values.
  - Reset mid-count discards the partial count. No `chg` fires on reset release.
- **Reset release with input ≠ `RS`:** a normal change then occurs after `SS`+`DBC` qualified cycles. It is not suppressed.

## Timing
- **Latency with `en`=1, measured from the first clock edge that samples a new stable `i`:**
  - `s` changes at edge `SS`.
  - `o` and `chg` change at edge `SS`+`DBC`.
  - With `DBC`=0, `o` changes at edge `SS`+1.
- **Latency with a sparse `en`:** `o` updates on the `DBC`-th `en`-high clock while `s`≠`o`. Cycles with `en`=0 neither count nor reset.
- **Glitch rejection:** a pulse on `s` shorter than `DBC` qualified cycles never reaches `o`.
- **`en` and an `s` change on the same edge:** the counter compares against the pre-edge `s`. The new mismatch begins counting on the next `en`.
- **Edge pulses:** `rise`/`fall` are registered with the same timing as `chg`.

## Configuration
- **`I_SYNC_DB_EDGE_EN` defined:** `rise`/`fall` ports and their flops exist.
  - `rise`[n] = 1 exactly when `chg`[n]=1 and the new `o`[n]=1.
  - `fall`[n] = 1 exactly when `chg`[n]=1 and the new `o`[n]=0.
- **`I_SYNC_DB_EDGE_EN` not defined:** the `rise`/`fall` ports are absent. `o`/`chg` behaviour is identical.

## Structure
- **Shared IO package/header:** the `SS` legal-range limits (2, 4), the maximum `DBC` (255) and the `CW` computation function.
- **Sub-module `i_sync_db_ch`:** one channel, holding the sync chain, counter and output flop. It is instanced `DW` times by a generate loop.
- **Top level:** fans out `clk`/`rst`/`en` and concatenates outputs.
- **Parameter checks:** out-of-range `SS`/`DBC` trigger an elaboration-time `$error`.

## Test plan
All scenarios use `DW`=4, `SS`=2, `DBC`=3 and `en`=1 unless stated otherwise.
- **Reset:**
  - With `RS`=0: hold `rst` 3 cycles with `i`=4'hF → `o`=0, `chg`=0 throughout.
  - With `RS`=1: the same stimulus → `o`=4'hF, `chg`=0.
- **Clean step:** `i[0]` 0→1 stable → `o[0]`=1 at edge 5. `chg[0]` and `rise[0]` high for exactly that cycle. Other bits stay 0.
- **Glitch:** `i[1]` high for 2 cycles then low → `o[1]` stays 0 and `chg` stays 0 for 20 cycles. A bounce 1,0,1 within the count restarts it, so `o` updates 3 qualified cycles after the last transition.
- **Sparse `en`:** `en` every 4th cycle, `i[2]` 0→1 → `o[2]` rises on the 3rd `en` cycle after `s[2]`=1, not earlier.
- **Reset mid-count:** `i[3]` 0→1, assert `rst` at edge 4 for 1 cycle → `o[3]` stays 0 at edge 5. After release it rises at edge 4+1+`SS`+`DBC`, with no spurious `chg`.
- **Bypass:** with `DBC`=0 and `SS`=3, `i` toggles every cycle → `o` follows `i` delayed by 4 edges, and `chg`=4'hF every cycle once the pipeline is filled.
